// File: rtl/axis_framing_pkg.sv
// +------------------------------------------------------------------+
// | axis_framing_pkg : shared types and round-robin search helper    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package axis_framing_pkg;

  localparam int RR_MAX_PORTS = 16;
  localparam int RR_IDX_W     = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_result_t;

  // First set bit of req searching ptr+1, ptr+2, ... modulo num_ports.
  // ptr < num_ports and k <= num_ports, so one conditional subtract wraps.
  function automatic rr_result_t rr_next(
    input logic [RR_MAX_PORTS-1:0] req,
    input logic [RR_IDX_W-1:0]     ptr,
    input int unsigned             num_ports
  );
    rr_result_t  res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 1; k <= RR_MAX_PORTS; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= num_ports) cand = cand - num_ports;
      if (!res.found && (k <= num_ports) && req[cand[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin picker (req, last ptr)    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import axis_framing_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [ID_WIDTH-1:0]  i_ptr,
  output logic                 o_found,
  output logic [ID_WIDTH-1:0]  o_idx
);

  logic [RR_MAX_PORTS-1:0] w_req_ext;
  rr_result_t              w_res;

  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_PORTS-1:0] = i_req;
  end

  assign w_res   = rr_next(w_req_ext, RR_IDX_W'(i_ptr), unsigned'(NUM_PORTS));
  assign o_found = w_res.found;
  assign o_idx   = ID_WIDTH'(w_res.idx);

endmodule

`default_nettype wire

// File: rtl/axis_frame_arbiter.sv
// +------------------------------------------------------------------+
// | axis_frame_arbiter : frame-locked round-robin AXI4-Stream mux    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module axis_frame_arbiter
  import axis_framing_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_PORTS-1:0]            port_enable,
  input  logic [NUM_PORTS-1:0]            target_tvalid,
  output logic [NUM_PORTS-1:0]            target_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] target_tdata,
  input  logic [NUM_PORTS-1:0]            target_tlast,
  output logic                            initiator_tvalid,
  input  logic                            initiator_tready,
  output logic [DATA_WIDTH-1:0]           initiator_tdata,
  output logic                            initiator_tlast,
  output logic [ID_WIDTH-1:0]             initiator_tid,
  output logic                            busy
);

  arb_state_t            r_state;
  logic [ID_WIDTH-1:0]   r_grant_idx;
  logic [ID_WIDTH-1:0]   r_rr_ptr;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_win_idx;
  logic                  w_locked;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_release;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_rr_arbiter (
    .i_req   (target_tvalid & port_enable),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_win_idx)
  );

  assign w_locked = (r_state == LOCKED);

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant_idx == ID_WIDTH'(i)) begin
        w_sel_valid = target_tvalid[i];
        w_sel_last  = target_tlast[i];
        w_sel_data  = target_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    target_tready = '0;
    if (w_locked) target_tready[r_grant_idx] = initiator_tready;
  end

  // Outputs are forced quiet in IDLE so the arbitration bubble is clean.
  assign initiator_tvalid = w_locked & w_sel_valid;
  assign initiator_tlast  = w_locked & w_sel_last;
  assign initiator_tdata  = w_locked ? w_sel_data : '0;
  assign initiator_tid    = w_locked ? r_grant_idx : '0;
  assign busy             = w_locked;

  assign w_release = initiator_tvalid & initiator_tready & initiator_tlast;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= ID_WIDTH'(NUM_PORTS - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_idx <= w_win_idx;
            r_state     <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_release) begin
            r_rr_ptr <= r_grant_idx;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_arbiter.sv
// +------------------------------------------------------------------+
// | tb_axis_frame_arbiter : vector table, directed frames, random    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_axis_frame_arbiter;

  logic        aclk;
  logic        areset;
  logic [3:0]  port_enable;
  logic [3:0]  target_tvalid;
  logic [3:0]  target_tready;
  logic [31:0] target_tdata;
  logic [3:0]  target_tlast;
  logic        initiator_tvalid;
  logic        initiator_tready;
  logic [7:0]  initiator_tdata;
  logic        initiator_tlast;
  logic [1:0]  initiator_tid;
  logic        busy;

  axis_frame_arbiter #(
    .NUM_PORTS  (4),
    .DATA_WIDTH (8)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .port_enable      (port_enable),
    .target_tvalid    (target_tvalid),
    .target_tready    (target_tready),
    .target_tdata     (target_tdata),
    .target_tlast     (target_tlast),
    .initiator_tvalid (initiator_tvalid),
    .initiator_tready (initiator_tready),
    .initiator_tdata  (initiator_tdata),
    .initiator_tlast  (initiator_tlast),
    .initiator_tid    (initiator_tid),
    .busy             (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: owner of the link (-1 when free) and last winner.
  int m_owner = -1;
  int m_last  = 3;

  function automatic int m_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++)
      if (req[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  always @(posedge aclk) begin
    if (areset) begin
      m_owner <= -1;
      m_last  <= 3;
    end else if (m_owner < 0) begin
      m_owner <= m_pick(target_tvalid & port_enable, m_last);
    end else if (target_tvalid[m_owner] && initiator_tready && target_tlast[m_owner]) begin
      m_last  <= m_owner;
      m_owner <= -1;
    end
  end

  task automatic model_check();
    logic [3:0] e_tr;
    logic       e_v;
    e_tr = 4'h0;
    e_v  = 1'b0;
    if (m_owner >= 0) begin
      e_v  = target_tvalid[m_owner];
      e_tr[m_owner] = initiator_tready;
    end
    chk("m_tvalid", 32'(initiator_tvalid), 32'(e_v));
    chk("m_tready", 32'(target_tready), 32'(e_tr));
    chk("m_busy",   32'(busy), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("m_tlast", 32'(initiator_tlast), 32'(target_tlast[m_owner]));
    if (e_v) begin
      chk("m_tdata", 32'(initiator_tdata), 32'(target_tdata[m_owner*8 +: 8]));
      chk("m_tid",   32'(initiator_tid), m_owner);
    end
  endtask

  // Frame sources used by the directed sequences.
  int src_beats[4];
  int src_frames[4];
  int src_len[4];
  int src_cnt[4];
  logic [3:0] r_hs;
  int q_tid[$];
  int q_data[$];

  task automatic src_clear();
    for (int p = 0; p < 4; p++) begin
      src_beats[p] = 0; src_frames[p] = 0; src_len[p] = 0; src_cnt[p] = 0;
    end
    q_tid.delete();
    q_data.delete();
  endtask

  task automatic src_half_a();
    for (int p = 0; p < 4; p++) begin
      target_tvalid[p]       = (src_beats[p] > 0);
      target_tlast[p]        = (src_beats[p] == 1);
      target_tdata[p*8 +: 8] = 8'((p << 4) | src_cnt[p]);
    end
    #4;
    model_check();
    r_hs = target_tready & target_tvalid;
    if (initiator_tvalid && initiator_tready) begin
      q_tid.push_back(int'(initiator_tid));
      q_data.push_back(int'(initiator_tdata));
    end
  endtask

  task automatic src_half_b();
    @(posedge aclk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (r_hs[p]) begin
        src_beats[p]--;
        src_cnt[p]++;
        if (src_beats[p] == 0 && src_frames[p] > 0) begin
          src_frames[p]--;
          src_beats[p] = src_len[p];
          src_cnt[p]   = 0;
        end
      end
    end
  endtask

  task automatic src_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      src_half_a();
      src_half_b();
    end
  endtask

  task automatic chk_tids(input string nm, input int exp[$]);
    chk({nm, "_count"}, q_tid.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk({nm, "_tid"}, (i < q_tid.size()) ? q_tid[i] : 32'hFF, exp[i]);
  endtask

  typedef struct {
    logic [3:0]  en, tv, tl;
    logic [31:0] data;
    logic        itr;
    logic [3:0]  e_tready;
    logic        e_valid, e_last;
    logic [7:0]  e_data;
    logic [1:0]  e_tid;
    logic        e_busy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Port 1 three-beat frame, then masked grant of port 3 with mid-frame disable.
    tbl[0]  = '{4'hF, 4'h0, 4'h0, 32'h0,        1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1]  = '{4'hF, 4'h2, 4'h0, 32'hD3D211D0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[2]  = '{4'hF, 4'h2, 4'h0, 32'hD3D211D0, 1'b1, 4'h2, 1'b1, 1'b0, 8'h11, 2'd1, 1'b1};
    tbl[3]  = '{4'hF, 4'h2, 4'h0, 32'hD3D222D0, 1'b1, 4'h2, 1'b1, 1'b0, 8'h22, 2'd1, 1'b1};
    tbl[4]  = '{4'hF, 4'h2, 4'h2, 32'hD3D233D0, 1'b1, 4'h2, 1'b1, 1'b1, 8'h33, 2'd1, 1'b1};
    tbl[5]  = '{4'hF, 4'h0, 4'h0, 32'h0,        1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[6]  = '{4'hB, 4'hC, 4'h0, 32'hA1C2C1C0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[7]  = '{4'h3, 4'hC, 4'h0, 32'hA1C2C1C0, 1'b1, 4'h8, 1'b1, 1'b0, 8'hA1, 2'd3, 1'b1};
    tbl[8]  = '{4'h3, 4'hC, 4'h8, 32'hA2C2C1C0, 1'b1, 4'h8, 1'b1, 1'b1, 8'hA2, 2'd3, 1'b1};
    tbl[9]  = '{4'h3, 4'hC, 4'h0, 32'hA2C2C1C0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[10] = '{4'h3, 4'hC, 4'h0, 32'hA2C2C1C0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[11] = '{4'hF, 4'h0, 4'h0, 32'h0,        1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};

    areset = 1'b1; port_enable = 4'h0; target_tvalid = 4'h0;
    target_tdata = 32'h0; target_tlast = 4'h0; initiator_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      port_enable = tbl[i].en; target_tvalid = tbl[i].tv; target_tlast = tbl[i].tl;
      target_tdata = tbl[i].data; initiator_tready = tbl[i].itr;
      #4;
      chk($sformatf("v%0d_tready", i), 32'(target_tready),    32'(tbl[i].e_tready));
      chk($sformatf("v%0d_tvalid", i), 32'(initiator_tvalid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_tlast", i),  32'(initiator_tlast),  32'(tbl[i].e_last));
      chk($sformatf("v%0d_busy", i),   32'(busy),             32'(tbl[i].e_busy));
      if (tbl[i].e_valid || i == 0)
        chk($sformatf("v%0d_tid", i), 32'(initiator_tid), 32'(tbl[i].e_tid));
      if (tbl[i].e_valid)
        chk($sformatf("v%0d_tdata", i), 32'(initiator_tdata), 32'(tbl[i].e_data));
      @(posedge aclk);
      #1;
    end

    // Three ports each with a 2-beat frame from the same cycle.
    port_enable = 4'hF; initiator_tready = 1'b1;
    src_clear();
    for (int p = 0; p < 3; p++) begin src_beats[p] = 2; src_len[p] = 2; end
    src_cycles(14);
    chk_tids("order3", '{0, 0, 1, 1, 2, 2});

    // Port 3 streams two frames; port 0 joins once port 3 holds the link.
    src_clear();
    src_beats[3] = 2; src_len[3] = 2; src_frames[3] = 1;
    src_cycles(1);
    src_beats[0] = 2; src_len[0] = 2;
    src_cycles(11);
    chk_tids("fair", '{3, 3, 0, 0, 3, 3});

    // Port 2 three-beat frame with downstream stalls.
    src_clear();
    src_beats[2] = 3; src_len[2] = 3;
    begin
      logic itr_pat[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int c = 0; c < 8; c++) begin
        initiator_tready = itr_pat[c];
        src_half_a();
        src_half_b();
      end
    end
    initiator_tready = 1'b1;
    chk_tids("stall", '{2, 2, 2});
    for (int i = 0; i < 3; i++)
      chk("stall_data", (i < q_data.size()) ? q_data[i] : 32'hFFFF, 32'h20 + i);

    // Reset during the second beat of a 4-beat frame on port 1.
    src_clear();
    src_beats[1] = 4; src_len[1] = 4;
    src_cycles(2);
    areset = 1'b1;
    src_cycles(1);
    areset = 1'b0;
    src_clear();
    src_beats[0] = 1; src_len[0] = 1;
    src_beats[1] = 1; src_len[1] = 1;
    src_half_a();
    chk("rst_busy",   32'(busy), 32'h0);
    chk("rst_tvalid", 32'(initiator_tvalid), 32'h0);
    chk("rst_tready", 32'(target_tready), 32'h0);
    chk("rst_tlast",  32'(initiator_tlast), 32'h0);
    chk("rst_tid",    32'(initiator_tid), 32'h0);
    src_half_b();
    src_cycles(6);
    chk_tids("post_rst", '{0, 1});

    // Unconstrained random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      areset           = ($urandom_range(0, 199) == 0);
      port_enable      = 4'($urandom) | 4'($urandom);
      target_tvalid    = 4'($urandom);
      target_tlast     = 4'($urandom);
      target_tdata     = $urandom;
      initiator_tready = 1'($urandom);
      #4;
      model_check();
      @(posedge aclk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
